// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clears every register after reset, then
// shares the single write port between an ALU and a load requester (round-robin).
module regfile_write_arbiter #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         AluValid,
  input  logic [D-1:0] AluAddr,
  input  logic [W-1:0] AluData,
  output logic         AluReady,
  input  logic         MemValid,
  input  logic [D-1:0] MemAddr,
  input  logic [W-1:0] MemData,
  output logic         MemReady,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         InitBusy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [D-1:0] LAST_ADDR = '1;

  state_t         r_state;
  state_t         w_state_next;
  logic [D-1:0]   r_cnt;

  logic           r_alu_full;
  logic [D-1:0]   r_alu_addr;
  logic [W-1:0]   r_alu_data;
  logic           r_mem_full;
  logic [D-1:0]   r_mem_addr;
  logic [W-1:0]   r_mem_data;
  logic           r_ptr_mem;

  logic           r_wen;
  logic [D-1:0]   r_waddr;
  logic [W-1:0]   r_wdata;

  logic           w_in_run;
  logic           w_alu_acc;
  logic           w_mem_acc;
  logic           w_grant_alu;
  logic           w_grant_mem;

  // Ready depends only on registered state, so Valid never loops back into Ready.
  assign w_in_run    = (r_state == S_RUN);
  assign AluReady    = w_in_run & ~r_alu_full;
  assign MemReady    = w_in_run & ~r_mem_full;
  assign InitBusy    = ~w_in_run;
  assign w_alu_acc   = AluValid & AluReady;
  assign w_mem_acc   = MemValid & MemReady;
  assign w_grant_alu = w_in_run & r_alu_full & (~r_mem_full | ~r_ptr_mem);
  assign w_grant_mem = w_in_run & r_mem_full & (~r_alu_full | r_ptr_mem);

  assign WriteEn = r_wen;
  assign Waddr   = r_waddr;
  assign DataIn  = r_wdata;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == LAST_ADDR) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_cnt      <= '0;
      r_alu_full <= 1'b0;
      r_alu_addr <= '0;
      r_alu_data <= '0;
      r_mem_full <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_ptr_mem  <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else if (r_state == S_INIT) begin
      r_wen   <= 1'b1;
      r_waddr <= r_cnt;
      r_wdata <= '0;
      r_cnt   <= r_cnt + 1'b1;
    end else begin
      // Accept needs an empty buffer and grant needs a full one, so they never collide.
      if (w_alu_acc) begin
        r_alu_full <= 1'b1;
        r_alu_addr <= AluAddr;
        r_alu_data <= AluData;
      end else if (w_grant_alu) begin
        r_alu_full <= 1'b0;
      end

      if (w_mem_acc) begin
        r_mem_full <= 1'b1;
        r_mem_addr <= MemAddr;
        r_mem_data <= MemData;
      end else if (w_grant_mem) begin
        r_mem_full <= 1'b0;
      end

      if (r_alu_full && r_mem_full) begin
        r_ptr_mem <= ~r_ptr_mem;
      end

      if (w_grant_alu) begin
        r_wen   <= 1'b1;
        r_waddr <= r_alu_addr;
        r_wdata <= r_alu_data;
      end else if (w_grant_mem) begin
        r_wen   <= 1'b1;
        r_waddr <= r_mem_addr;
        r_wdata <= r_mem_data;
      end else begin
        r_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, per-cycle behavioural model,
// and a write log used for ordering checks.
module tb_regfile_write_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       AluValid;
  logic [3:0] AluAddr;
  logic [7:0] AluData;
  logic       AluReady;
  logic       MemValid;
  logic [3:0] MemAddr;
  logic [7:0] MemData;
  logic       MemReady;
  logic       WriteEn;
  logic [3:0] Waddr;
  logic [7:0] DataIn;
  logic       InitBusy;

  regfile_write_arbiter #(.W(8), .D(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .InitBusy(InitBusy)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;
  bit log_en  = 0;
  bit seen99  = 0;

  typedef struct { int c; logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: what the register-file port must show, from the rules.
  bit       m_init = 1;
  int       m_walk = 0;
  bit       m_full[2];
  logic [3:0] m_addr[2];
  logic [7:0] m_data[2];
  int       m_rr = 0;
  bit       m_we = 0;
  logic [3:0] m_wa = 0;
  logic [7:0] m_wd = 0;

  always @(posedge Clk) begin
    bit acc0, acc1;
    int g;
    cyc++;
    acc0 = AluValid && !m_init && !m_full[0];
    acc1 = MemValid && !m_init && !m_full[1];
    if (!Reset) begin
      m_init = 1; m_walk = 0; m_full[0] = 0; m_full[1] = 0; m_rr = 0;
      m_we = 0; m_wa = 0; m_wd = 0;
    end else if (m_init) begin
      m_we = 1; m_wa = 4'(m_walk); m_wd = 0;
      if (m_walk == 15) m_init = 0;
      m_walk++;
    end else begin
      g = -1;
      if (m_full[0] && m_full[1]) begin g = m_rr; m_rr = 1 - m_rr; end
      else if (m_full[0]) g = 0;
      else if (m_full[1]) g = 1;
      if (g >= 0) begin
        m_we = 1; m_wa = m_addr[g]; m_wd = m_data[g]; m_full[g] = 0;
      end else begin
        m_we = 0;
      end
      if (acc0) begin m_full[0] = 1; m_addr[0] = AluAddr; m_data[0] = AluData; end
      if (acc1) begin m_full[1] = 1; m_addr[1] = MemAddr; m_data[1] = MemData; end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_wen", WriteEn, m_we);
      if (m_we) begin
        check("model_waddr", Waddr, m_wa);
        check("model_data", DataIn, m_wd);
      end
      check("model_alu_ready", AluReady, !m_init && !m_full[0]);
      check("model_mem_ready", MemReady, !m_init && !m_full[1]);
      check("model_init_busy", InitBusy, m_init);
    end
    if (log_en && WriteEn) wlog.push_back('{cyc, Waddr, DataIn});
    if (WriteEn && DataIn == 8'h99) seen99 = 1;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [7:0] ad, md;
    logic [7:0] exp_a[$];
    logic [7:0] exp_m[$];
    bit ra, rm;
    Reset = 0; AluValid = 0; AluAddr = 0; AluData = 0;
    MemValid = 0; MemAddr = 0; MemData = 0;

    // Reset and clear walk
    tick; chk_en = 1;
    repeat (2) tick;
    check("rst_wen", WriteEn, 0);
    check("rst_waddr", Waddr, 0);
    check("rst_busy", InitBusy, 1);
    check("rst_alu_ready", AluReady, 0);
    check("rst_mem_ready", MemReady, 0);
    Reset = 1;
    for (int i = 0; i < 16; i++) begin
      tick;
      check("walk_wen", WriteEn, 1);
      check("walk_addr", Waddr, i);
      check("walk_data", DataIn, 0);
      if (i < 15) check("walk_busy", InitBusy, 1);
    end
    check("run_busy", InitBusy, 0);
    check("run_alu_ready", AluReady, 1);
    check("run_mem_ready", MemReady, 1);
    tick;
    check("run_idle_wen", WriteEn, 0);

    // Single ALU write
    AluValid = 1; AluAddr = 3; AluData = 8'h1E;
    tick; AluValid = 0;
    check("alu1_ready_low", AluReady, 0);
    check("alu1_wen_pre", WriteEn, 0);
    tick;
    check("alu1_wen", WriteEn, 1);
    check("alu1_addr", Waddr, 3);
    check("alu1_data", DataIn, 8'h1E);
    check("alu1_ready_back", AluReady, 1);
    tick;
    check("alu1_done", WriteEn, 0);
    check("alu1_hold_addr", Waddr, 3);

    // Simultaneous accept, twice: ALU first, then Mem first
    for (int r = 0; r < 2; r++) begin
      AluValid = 1; AluAddr = 5; AluData = 8'hAA;
      MemValid = 1; MemAddr = 6; MemData = 8'h55;
      tick; AluValid = 0; MemValid = 0;
      tick;
      check("dual_first_addr", Waddr, (r == 0) ? 5 : 6);
      check("dual_first_data", DataIn, (r == 0) ? 8'hAA : 8'h55);
      tick;
      check("dual_second_wen", WriteEn, 1);
      check("dual_second_addr", Waddr, (r == 0) ? 6 : 5);
      check("dual_second_data", DataIn, (r == 0) ? 8'h55 : 8'hAA);
      tick;
    end

    // Same destination from both requesters, pointer back at ALU
    AluValid = 1; AluAddr = 7; AluData = 8'h11;
    MemValid = 1; MemAddr = 7; MemData = 8'h22;
    tick; AluValid = 0; MemValid = 0;
    tick;
    check("same_first_addr", Waddr, 7);
    check("same_first_data", DataIn, 8'h11);
    tick;
    check("same_last_addr", Waddr, 7);
    check("same_last_data", DataIn, 8'h22);
    tick;

    // Both requesters streaming (pointer now at Mem)
    wlog.delete();
    log_en = 1;
    AluValid = 1; MemValid = 1; AluAddr = 1; MemAddr = 2;
    ad = 8'h40; md = 8'hC0;
    for (int c = 0; c < 8; c++) begin
      AluData = ad; MemData = md;
      ra = AluReady; rm = MemReady;
      tick;
      if (ra) begin exp_a.push_back(ad); ad++; end
      if (rm) begin exp_m.push_back(md); md++; end
    end
    AluValid = 0; MemValid = 0;
    repeat (3) tick;
    log_en = 0;
    check("stream_accepts", exp_a.size() + exp_m.size(), 8);
    check("stream_writes", wlog.size(), exp_a.size() + exp_m.size());
    if (wlog.size() > 0) check("stream_first_src", wlog[0].a, 2);
    for (int k = 0; k < wlog.size(); k++) begin
      if (k > 0) begin
        check("stream_back_to_back", wlog[k].c, wlog[k-1].c + 1);
        check("stream_alternate", wlog[k].a != wlog[k-1].a, 1);
      end
      if (wlog[k].a == 1 && exp_a.size() > 0) check("stream_alu_data", wlog[k].d, exp_a.pop_front());
      else if (wlog[k].a == 2 && exp_m.size() > 0) check("stream_mem_data", wlog[k].d, exp_m.pop_front());
      else check("stream_unexpected_write", {wlog[k].a, wlog[k].d}, 0);
    end
    check("stream_left_over", exp_a.size() + exp_m.size(), 0);

    // Reset with a load pending
    MemValid = 1; MemAddr = 9; MemData = 8'h99;
    tick; MemValid = 0;
    check("mrst_mem_ready", MemReady, 0);
    Reset = 0;
    tick;
    check("mrst_wen", WriteEn, 0);
    check("mrst_busy", InitBusy, 1);
    Reset = 1;
    for (int i = 0; i < 16; i++) begin
      tick;
      check("mrst_walk_addr", Waddr, i);
      check("mrst_walk_data", DataIn, 0);
      if (i < 15) check("mrst_mem_ready_low", MemReady, 0);
    end
    check("mrst_mem_ready_high", MemReady, 1);
    repeat (4) tick;
    check("mrst_no_stale_write", seen99, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
